// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 receiver.
package spi_pkg;

    // Frame state: IDLE while CS is high, ACTIVE while CS is low.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int SPI_BITS_PER_BYTE       = 8;
    localparam int SPI_SYNC_STAGES_DEFAULT = 2;
    localparam int SPI_CNT_W               = $clog2(SPI_BITS_PER_BYTE);

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchroniser with configurable depth and reset value.
// DEPTH must be at least 2.
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift the asynchronous input through DEPTH flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {DEPTH{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_receiver.sv
// SPI mode-0 target front end: synchronises cs/sclk/mosi into the clk domain,
// assembles MSB-first bytes and emits rx_valid / frame_start / frame_end pulses.
// Optional reply path on spi_miso is built when SPI_MISO_EN is defined;
// otherwise spi_miso and tx_ack are tied low and tx_data is ignored.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data, with no
// backpressure. tx_ack is a one-cycle strobe; tx_data is loaded into the reply
// register on the clock edge at which tx_ack rises, so tx_data must be stable
// in the cycle before tx_ack and may change once tx_ack is seen.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_start,
    output logic       frame_end,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output spi_state_t dbg_state
);

    logic cs_s, sclk_s, mosi_s;

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (spi_cs),
        .q_o   (cs_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (spi_sclk),
        .q_o   (sclk_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk),
        .rst_ni(reset_n),
        .d_i   (spi_mosi),
        .q_o   (mosi_s)
    );

    // Edge history and post-reset warm-up. The synchronisers come out of reset
    // holding their reset values, so whatever the pins really are shows up as
    // a fake edge SYNC_STAGES cycles after release. Edges are ignored until
    // that has flushed through, so a CS held low across reset does not open a
    // frame; a fresh CS fall is needed.
    logic       cs_prev_q, sclk_prev_q;
    logic [1:0] warm_q;
    logic       armed_q;

    // Previous-value flops for edge detection and the warm-up counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            warm_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            if (!armed_q) begin
                warm_q  <= warm_q + 2'd1;
                armed_q <= (warm_q == 2'(SYNC_STAGES));
            end
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_fall   = armed_q &  cs_prev_q   & ~cs_s;
    assign cs_rise   = armed_q & ~cs_prev_q   &  cs_s;
    assign sclk_rise = armed_q & ~sclk_prev_q &  sclk_s;
    assign sclk_fall = armed_q &  sclk_prev_q & ~sclk_s;

    spi_state_t            state_q, state_d;
    logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_end_q, frame_end_d;

    // Frame state, bit counter, receive shift register and output pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    // Next-state logic: CS edges take priority over sclk edges in the same cycle.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                shift_d   = '0;
                if (cs_fall) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // Any partial byte is dropped here.
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == SPI_CNT_W'(SPI_BITS_PER_BYTE - 1)) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign dbg_state   = state_q;

`ifdef SPI_MISO_EN
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_ack_q, tx_ack_d;

    // Reply shift register and capture strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift_q <= '0;
            tx_ack_q   <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_ack_q   <= tx_ack_d;
        end
    end

    // Load a reply byte at frame start and after each byte; shift on sclk falls.
    // The fall right after a byte boundary (counter back at 0) must not shift,
    // since the freshly loaded MSB is already on the line for the next rise.
    always_comb begin
        tx_ack_d   = frame_start_d | rx_valid_d;
        tx_shift_d = tx_shift_q;
        if (tx_ack_d) begin
            tx_shift_d = tx_data;
        end else if (state_q == ACTIVE && sclk_fall && bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
        if (state_d == IDLE) begin
            tx_shift_d = '0;
        end
    end

    assign spi_miso = (state_q == ACTIVE) ? tx_shift_q[7] : 1'b0;
    assign tx_ack   = tx_ack_q;
`else
    logic unused_tx;
    assign unused_tx = (^tx_data) ^ sclk_fall;
    assign spi_miso  = 1'b0;
    assign tx_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: reset behaviour, single byte, burst,
// aborted byte, reply echo (when SPI_MISO_EN is defined) and reset mid-byte.
module tb_spi_receiver;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_cs, spi_sclk, spi_mosi;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid, frame_start, frame_end;
    logic [7:0] tx_data;
    logic       tx_ack;
    spi_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    int n_rx = 0, n_fs = 0, n_fe = 0, n_ack = 0;
    logic [7:0] rx_log[$];
    logic [7:0] exp_q[$];
    int         rx_idx = 0;
    logic [15:0] miso_sr = '0;

    spi_receiver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_cs     (spi_cs),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .dbg_state  (dbg_state)
    );

    // Clock: 10 time units per period.
    always #5 clk = ~clk;

    // Monitor: count strobes and log received bytes on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_rx++;
            rx_log.push_back(rx_data);
        end
        if (frame_start) n_fs++;
        if (frame_end)   n_fe++;
        if (tx_ack)      n_ack++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: data set while sclk low, host samples miso at the rise.
    task automatic send_bit(input logic b);
        spi_mosi = b;
        wait_clks(8);
        spi_sclk = 1'b1;
        miso_sr  = {miso_sr[14:0], spi_miso};
        wait_clks(8);
        spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        exp_q.push_back(b);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        wait_clks(8);
    endtask

    task automatic cs_high();
        wait_clks(8);
        spi_cs = 1'b1;
        wait_clks(10);
    endtask

    // Compare logged bytes against the expected queue, then drain it.
    task automatic scoreboard(input string tag);
        int got;
        int n;
        got = rx_log.size() - rx_idx;
        check({tag, "_count"}, got, exp_q.size());
        n = (got < exp_q.size()) ? got : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_log[rx_idx + i], exp_q[i]);
        end
        exp_q.delete();
        rx_idx = rx_log.size();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_valid"},    rx_valid,    1'b0);
        check({tag, "_frame_start"}, frame_start, 1'b0);
        check({tag, "_frame_end"},   frame_end,   1'b0);
        check({tag, "_rx_data"},     rx_data,     8'h00);
        check({tag, "_miso"},        spi_miso,    1'b0);
        check({tag, "_tx_ack"},      tx_ack,      1'b0);
        check({tag, "_state"},       dbg_state,   IDLE);
    endtask

    initial begin
        int fs0, fe0, rx0, ack0;

        // Reset held with CS low and sclk toggling.
        reset_n  = 1'b0;
        spi_cs   = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        tx_data  = 8'hC3;
        repeat (10) begin
            wait_clks(2);
            spi_sclk = ~spi_sclk;
            spi_mosi = ~spi_mosi;
        end
        wait_clks(2);
        check_idle_outputs("reset");

        // Release with CS still low: no frame may open.
        reset_n = 1'b1;
        wait_clks(20);
        check("rel_no_fs", n_fs, 0);
        check("rel_state", dbg_state, IDLE);
        for (int i = 0; i < 8; i++) begin
            spi_sclk = ~spi_sclk;
            wait_clks(6);
        end
        check("rel_no_rx", n_rx, 0);
        spi_cs = 1'b1;
        wait_clks(10);
        check("rel_no_fe", n_fe, 0);

        // Sclk activity in IDLE is ignored.
        for (int i = 0; i < 16; i++) begin
            spi_sclk = ~spi_sclk;
            spi_mosi = 1'b1;
            wait_clks(6);
        end
        check("idle_sclk_no_rx", n_rx, 0);

        // Single byte 0xA5, plus frame_start latency (3 cycles after CS pin fall).
        fs0 = n_fs; fe0 = n_fe; ack0 = n_ack;
        miso_sr = '0;
        spi_cs = 1'b0;
        wait_clks(2);
        check("fs_not_early", frame_start, 1'b0);
        wait_clks(1);
        check("fs_latency", frame_start, 1'b1);
        wait_clks(5);
        send_byte(8'hA5);
        cs_high();
        check("single_fs", n_fs - fs0, 1);
        check("single_fe", n_fe - fe0, 1);
        scoreboard("single");
        check("single_hold", rx_data, 8'hA5);
`ifndef SPI_MISO_EN
        check("no_miso", miso_sr, 16'h0000);
        check("no_tx_ack", n_ack - ack0, 0);
`endif

        // Burst of three bytes in one frame.
        fs0 = n_fs; fe0 = n_fe;
        cs_low();
        send_byte(8'h3C);
        send_byte(8'hFF);
        send_byte(8'h00);
        cs_high();
        check("burst_fs", n_fs - fs0, 1);
        check("burst_fe", n_fe - fe0, 1);
        scoreboard("burst");

        // Aborted 5-bit byte, then a clean frame with 0x81.
        fs0 = n_fs; fe0 = n_fe;
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        cs_high();
        cs_low();
        send_byte(8'h81);
        cs_high();
        check("abort_fs", n_fs - fs0, 2);
        check("abort_fe", n_fe - fe0, 2);
        scoreboard("abort");
        check("abort_hold", rx_data, 8'h81);

`ifdef SPI_MISO_EN
        // Reply echo: 0xC3 loaded at frame start, 0x5A loaded after byte one.
        // The second byte's completion also acks while still ACTIVE.
        ack0 = n_ack;
        miso_sr = '0;
        tx_data = 8'hC3;
        cs_low();
        check("echo_ack_start", n_ack - ack0, 1);
        send_bit(1'b0);
        tx_data = 8'h5A;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        exp_q.push_back(8'h7F);
        wait_clks(4);
        check("echo_ack_byte1", n_ack - ack0, 2);
        send_byte(8'h11);
        check("echo_miso", miso_sr, 16'hC35A);
        cs_high();
        check("echo_ack_total", n_ack - ack0, 3);
        check("echo_miso_idle", spi_miso, 1'b0);
        scoreboard("echo");
`endif

        // Reset asserted after 4 bits, released with CS low, then a fresh frame.
        cs_low();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_clks(2);
        fs0 = n_fs; fe0 = n_fe; rx0 = n_rx;
        reset_n = 1'b0;
        wait_clks(2);
        check_idle_outputs("midrst");
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(20);
        spi_cs = 1'b1;
        wait_clks(10);
        check("midrst_no_fe", n_fe - fe0, 0);
        check("midrst_no_fs", n_fs - fs0, 0);
        check("midrst_no_rx", n_rx - rx0, 0);
        rx_idx = rx_log.size();
        cs_low();
        send_byte(8'h12);
        cs_high();
        check("midrst_fs", n_fs - fs0, 1);
        check("midrst_fe", n_fe - fe0, 1);
        scoreboard("midrst");
        check("midrst_hold", rx_data, 8'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
